// File: rtl/norm_hw.sv
// Block-floating-point normaliser: per-vector max magnitude, left shift to fill 15 bits, ping-pong buffered.
// Optional status registers (last shift, completed-vector count) enabled by NORM_HW_STATUS_EN.
module norm_hw #(
  parameter int unsigned NPIPELINE = 10
) (
  input  logic        clk_proc,
  input  logic        reset_n,
  input  logic        in_fv,
  input  logic        in_dv,
  input  logic [15:0] in_data,
  output logic        out_fv,
  output logic        out_dv,
  output logic [15:0] out_data,
  input  logic [3:0]  addr_rel_i,
  input  logic        wr_i,
  input  logic [31:0] datawr_i,
  input  logic        rd_i,
  output logic [31:0] datard_o
);

  localparam int unsigned DW = 16;
  localparam int unsigned MW = 17;
  localparam int unsigned SW = 4;
  localparam int unsigned RW = 32;
  localparam int unsigned CW = $clog2(NPIPELINE + 1);
  localparam int unsigned AW = $clog2(2 * NPIPELINE);

  // Largest shift keeping m << s within 15 magnitude bits; 0 for m == 0 or m == 32768.
  function automatic logic [SW-1:0] shift_for(input logic [MW-1:0] m);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if ((m != '0) && ((32'(m) << i) <= 32'd32767)) s = SW'(i);
    end
    return s;
  endfunction

  logic [DW-1:0] mem [2*NPIPELINE];

  logic          enable_reg;
  logic          mode_norm;
  logic          wb;
  logic [CW-1:0] wcnt;
  logic [MW-1:0] wmax;
  logic [1:0]    full;
  logic [CW-1:0] blen [2];
  logic [MW-1:0] bmax [2];
  logic          rd_active;
  logic          rsel;
  logic          rcur;
  logic [CW-1:0] ridx;
  logic [CW-1:0] rlen;
  logic [SW-1:0] rshift;

  logic          accept_c;
  logic [MW-1:0] sx_c;
  logic [MW-1:0] mag_c;
  logic [MW-1:0] max_c;
  logic          last_in_c;
  logic          flush_c;
  logic          done_c;
  logic [AW-1:0] waddr_c;
  logic [AW-1:0] raddr_c;
  logic          rd_last_c;
  logic          start_c;
  logic          idle_c;
  logic [RW-1:0] rdata_c;

  always_comb begin
    accept_c  = in_fv & in_dv;
    sx_c      = {in_data[DW-1], in_data};
    mag_c     = sx_c[MW-1] ? MW'(~sx_c + MW'(1)) : sx_c;
    max_c     = (mag_c > wmax) ? mag_c : wmax;
    last_in_c = mode_norm & accept_c & (wcnt == CW'(NPIPELINE - 1));
    flush_c   = mode_norm & ~in_fv & (wcnt != '0);
    done_c    = last_in_c | flush_c;
    waddr_c   = (wb ? AW'(NPIPELINE) : '0) + AW'(wcnt);
    raddr_c   = (rcur ? AW'(NPIPELINE) : '0) + AW'(ridx);
    rd_last_c = rd_active & (ridx == rlen - CW'(1));
    start_c   = mode_norm & (~rd_active | rd_last_c) & full[rsel];
    idle_c    = (wcnt == '0) & (full == '0) & ~rd_active & ~accept_c;
  end

  // Sample storage; contents need no reset since counts and flags gate every read.
  always_ff @(posedge clk_proc) begin
    if (mode_norm && accept_c) mem[waddr_c] <= in_data;
  end

  always_ff @(posedge clk_proc or negedge reset_n) begin
    if (!reset_n) begin
      enable_reg <= 1'b1;
      mode_norm  <= 1'b1;
      wb         <= 1'b0;
      wcnt       <= '0;
      wmax       <= '0;
      full       <= '0;
      for (int i = 0; i < 2; i++) begin
        blen[i] <= '0;
        bmax[i] <= '0;
      end
      rd_active  <= 1'b0;
      rsel       <= 1'b0;
      rcur       <= 1'b0;
      ridx       <= '0;
      rlen       <= '0;
      rshift     <= '0;
      out_fv     <= 1'b0;
      out_dv     <= 1'b0;
      out_data   <= '0;
      datard_o   <= '0;
    end else begin
      if (wr_i && (addr_rel_i == 4'd0)) enable_reg <= datawr_i[0];
      // Mode only changes once nothing is buffered or in flight.
      if ((mode_norm != enable_reg) && (idle_c || !mode_norm)) mode_norm <= enable_reg;

      if (done_c) begin
        wcnt     <= '0;
        wmax     <= '0;
        wb       <= ~wb;
        blen[wb] <= last_in_c ? CW'(NPIPELINE) : wcnt;
        bmax[wb] <= last_in_c ? max_c : wmax;
      end else if (mode_norm && accept_c) begin
        wcnt <= wcnt + CW'(1);
        wmax <= max_c;
      end

      if (start_c) full[rsel] <= 1'b0;
      if (done_c) full[wb] <= 1'b1;

      // Reader latches length and shift at start, freeing the bank metadata immediately.
      if (start_c) begin
        rd_active <= 1'b1;
        rcur      <= rsel;
        rsel      <= ~rsel;
        ridx      <= '0;
        rlen      <= blen[rsel];
        rshift    <= shift_for(bmax[rsel]);
      end else if (rd_last_c) begin
        rd_active <= 1'b0;
      end else if (rd_active) begin
        ridx <= ridx + CW'(1);
      end

      if (mode_norm) begin
        out_fv   <= in_fv | (wcnt != '0) | (full != '0) | rd_active;
        out_dv   <= rd_active;
        out_data <= rd_active ? (mem[raddr_c] << rshift) : '0;
      end else begin
        out_fv   <= in_fv;
        out_dv   <= in_fv & in_dv;
        out_data <= in_data;
      end

      if (rd_i) datard_o <= rdata_c;
    end
  end

`ifdef NORM_HW_STATUS_EN
  logic [SW-1:0] last_shift;
  logic [RW-1:0] vec_cnt;

  always_ff @(posedge clk_proc or negedge reset_n) begin
    if (!reset_n) begin
      last_shift <= '0;
      vec_cnt    <= '0;
    end else begin
      if (start_c) last_shift <= shift_for(bmax[rsel]);
      if (rd_last_c) vec_cnt <= vec_cnt + RW'(1);
    end
  end
`endif

  always_comb begin
    rdata_c = '0;
    case (addr_rel_i)
      4'd0: rdata_c = RW'(enable_reg);
`ifdef NORM_HW_STATUS_EN
      4'd1: rdata_c = RW'(last_shift);
      4'd2: rdata_c = vec_cnt;
`endif
      default: rdata_c = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^datawr_i[RW-1:1];

endmodule

// File: tb/tb_norm_hw.sv
// Bench for norm_hw: random vectors against a queue-based vector model, plus register, bypass and reset scenarios.
// Honours NORM_HW_STATUS_EN for the status register expectations.
module tb_norm_hw;
  localparam int unsigned NP = 10;

  logic        clk_proc = 1'b0;
  logic        reset_n;
  logic        in_fv, in_dv;
  logic [15:0] in_data;
  logic        out_fv, out_dv;
  logic [15:0] out_data;
  logic [3:0]  addr_rel_i;
  logic        wr_i, rd_i;
  logic [31:0] datawr_i, datard_o;

  always #5 clk_proc = ~clk_proc;

  norm_hw #(.NPIPELINE(NP)) dut (
    .clk_proc(clk_proc), .reset_n(reset_n),
    .in_fv(in_fv), .in_dv(in_dv), .in_data(in_data),
    .out_fv(out_fv), .out_dv(out_dv), .out_data(out_data),
    .addr_rel_i(addr_rel_i), .wr_i(wr_i), .datawr_i(datawr_i),
    .rd_i(rd_i), .datard_o(datard_o)
  );

  typedef struct {
    logic [15:0] val;
    int          t;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] cur[$];
  int cyc = 0, next_free = 0, n_vec = 0;
  int n_checks = 0, n_errors = 0;
  int n_dv = 0, last_dv_cyc = 0, fv_fall_cyc = 0, n_fv_fall = 0;
  bit model_on = 1'b1;
  logic prev_fv = 1'b0;
  exp_t e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Close a vector completed at edge t: own max, shift, and output slots after any queued vector.
  task automatic finalize(input int t);
    int m, s, a, start;
    logic [31:0] w;
    exp_t x;
    m = 0;
    foreach (cur[i]) begin
      a = int'($signed(cur[i]));
      if (a < 0) a = -a;
      if (a > m) m = a;
    end
    s = 0;
    if (m != 0) for (int k = 0; k < 16; k++) if (m * (1 << k) <= 32767) s = k;
    start = (t + 2 > next_free) ? t + 2 : next_free;
    foreach (cur[i]) begin
      w = {16'b0, cur[i]} * (32'd1 << s);
      x.val = w[15:0];
      x.t = start + i;
      exp_q.push_back(x);
    end
    next_free = start + cur.size();
    n_vec++;
    cur.delete();
  endtask

  always @(posedge clk_proc) begin
    cyc++;
    if (!reset_n) begin
      cur.delete();
      exp_q.delete();
      next_free = 0;
      n_vec = 0;
    end else if (model_on) begin
      if (in_fv && in_dv) begin
        cur.push_back(in_data);
        if (cur.size() == NP) finalize(cyc);
      end else if (!in_fv && cur.size() != 0) begin
        finalize(cyc);
      end
    end
  end

  always @(posedge clk_proc) begin
    #1;
    if (model_on && reset_n) begin
      if (out_dv) begin
        check("dv_needs_fv", 32'(out_fv), 32'd1);
        n_dv++;
        last_dv_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_dv", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.val));
          check("out_time", cyc, e.t);
        end
      end else if (exp_q.size() != 0 && exp_q[0].t <= cyc) begin
        check("missing_dv", 32'd1, 32'd0);
        void'(exp_q.pop_front());
      end
    end
    if (prev_fv && !out_fv) begin
      fv_fall_cyc = cyc;
      n_fv_fall++;
    end
    prev_fv = out_fv;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_proc);
      #2;
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    addr_rel_i = a; datawr_i = d; wr_i = 1'b1;
    step();
    wr_i = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    addr_rel_i = a; rd_i = 1'b1;
    step();
    rd_i = 1'b0;
    d = datard_o;
  endtask

  task automatic send(input logic [15:0] d, input bit gaps);
    in_fv = 1'b1;
    if (gaps) while ($urandom_range(0, 2) == 0) begin in_dv = 1'b0; step(); end
    in_dv = 1'b1; in_data = d;
    step();
    in_dv = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || cur.size() != 0) && k < 300) begin step(); k++; end
    if (k >= 300) check("drain_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [15:0] rand_sample();
    logic [15:0] d;
    d = 16'($urandom);
    return 16'($signed(d) >>> $urandom_range(0, 15));
  endfunction

  initial begin
    logic [31:0] d;
    int falls0;
    reset_n = 1'b0; in_fv = 0; in_dv = 0; in_data = '0;
    addr_rel_i = '0; wr_i = 0; rd_i = 0; datawr_i = '0;
    step(3);
    check("rst_out_fv", 32'(out_fv), 0);
    check("rst_out_dv", 32'(out_dv), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_datard", datard_o, 0);
    #3 reset_n = 1'b1;
    step();
    reg_read(4'd0, d);
    check("enable_reset", d, 1);

    in_fv = 1'b1;
    step();
    check("fv_rise", 32'(out_fv), 1);

    for (int i = 0; i < NP; i++) send(16'h0001, 1'b0);
    wait_drain();

    send(16'hFFFF, 1'b0);
    for (int i = 1; i < NP; i++) send(16'h0000, 1'b0);
    wait_drain();
    step(2);
    reg_read(4'd1, d);
`ifdef NORM_HW_STATUS_EN
    check("last_shift", d, 14);
`else
    check("last_shift_absent", d, 0);
`endif

    for (int v = 0; v < 6; v++) for (int i = 0; i < NP; i++) send(rand_sample(), 1'b1);
    wait_drain();

    send(16'h8000, 1'b0);
    for (int i = 1; i < NP; i++) send(16'($urandom), 1'b1);
    for (int i = 0; i < NP; i++) send(16'h0000, 1'b1);
    wait_drain();

    n_dv = 0;
    in_fv = 1'b0;
    step(5);
    check("no_flush_dv", n_dv, 0);
    check("fv_low_idle", 32'(out_fv), 0);

    n_dv = 0;
    for (int i = 0; i < 127; i++) send(rand_sample(), 1'b1);
    in_fv = 1'b0;
    wait_drain();
    step(3);
    check("flush_count", n_dv, 127);
    check("fv_fall_after_last_dv", fv_fall_cyc, last_dv_cyc + 1);
    check("fv_low_after_flush", 32'(out_fv), 0);

    falls0 = n_fv_fall;
    for (int i = 0; i < 13; i++) send(rand_sample(), 1'b0);
    in_fv = 1'b0;
    step();
    for (int i = 0; i < 5; i++) send(rand_sample(), 1'b0);
    in_fv = 1'b0;
    wait_drain();
    step(3);
    check("fv_falls_once", n_fv_fall - falls0, 1);

    reg_read(4'd2, d);
`ifdef NORM_HW_STATUS_EN
    check("vec_count", d, n_vec);
`else
    check("vec_count_absent", d, 0);
`endif
    reg_write(4'd7, 32'hFFFF_FFFF);
    reg_read(4'd7, d);
    check("undef_addr", d, 0);

    for (int i = 0; i < 4; i++) send(rand_sample(), 1'b0);
    reg_write(4'd0, 32'd0);
    for (int i = 4; i < NP; i++) send(rand_sample(), 1'b0);
    wait_drain();
    step(3);
    model_on = 1'b0;
    reg_read(4'd0, d);
    check("enable_written", d, 0);
    for (int i = 0; i < 16; i++) begin
      logic fv, dv;
      logic [15:0] x;
      fv = ($urandom_range(0, 3) != 0);
      dv = $urandom_range(0, 1) == 1;
      x = 16'($urandom);
      in_fv = fv; in_dv = dv; in_data = x;
      step();
      check("byp_data", 32'(out_data), 32'(x));
      check("byp_dv", 32'(out_dv), 32'(fv & dv));
      check("byp_fv", 32'(out_fv), 32'(fv));
    end
    in_fv = 1'b0; in_dv = 1'b0;
    reg_write(4'd0, 32'd1);
    step(3);
    model_on = 1'b1;
    for (int i = 0; i < NP; i++) send(rand_sample(), 1'b1);
    wait_drain();
    reg_read(4'd0, d);
    check("enable_back", d, 1);

    for (int i = 0; i < NP + 2; i++) send(rand_sample(), 1'b0);
    reg_write(4'd0, 32'd0);
    for (int i = 0; i < 2; i++) send(rand_sample(), 1'b0);
    #1 reset_n = 1'b0;
    exp_q.delete();
    cur.delete();
    #1;
    check("async_rst_fv", 32'(out_fv), 0);
    check("async_rst_dv", 32'(out_dv), 0);
    check("async_rst_data", 32'(out_data), 0);
    check("async_rst_datard", datard_o, 0);
    in_fv = 1'b0; in_dv = 1'b0;
    step(2);
    #3 reset_n = 1'b1;
    n_dv = 0;
    step(15);
    check("no_stale_dv", n_dv, 0);
    check("fv_after_rst", 32'(out_fv), 0);
    reg_read(4'd0, d);
    check("enable_after_rst", d, 1);
    reg_read(4'd2, d);
    check("count_after_rst", d, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
